// File: rtl/ternary_dma_if.sv
// Shared trit encoding plus the bundle of command and data-memory signals
// between a host and the ternary DMA engine.
// Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1 (2'b10 is read as 0).

package ternary_dma_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b11;
endpackage

interface ternary_dma_if #(
    parameter int TRIT_WIDTH = 27,
    parameter int ADDR_WIDTH = 9
);
    // Command side
    logic                                      start;
    ternary_dma_pkg::trit_t [ADDR_WIDTH-1:0]   src_addr;
    ternary_dma_pkg::trit_t [ADDR_WIDTH-1:0]   dst_addr;
    logic [9:0]                                len;
    logic                                      fill;
    ternary_dma_pkg::trit_t [TRIT_WIDTH-1:0]   fill_word;
    logic                                      busy;
    logic                                      done;
    logic                                      err;

    // Data-memory side
    ternary_dma_pkg::trit_t [ADDR_WIDTH-1:0]   dmem_addr;
    ternary_dma_pkg::trit_t [TRIT_WIDTH-1:0]   dmem_wdata;
    ternary_dma_pkg::trit_t [TRIT_WIDTH-1:0]   dmem_rdata;
    logic                                      dmem_we;
    logic                                      dmem_re;

    // The DMA engine: takes commands, drives the memory port
    modport slave (
        input  start, src_addr, dst_addr, len, fill, fill_word, dmem_rdata,
        output busy, done, err, dmem_addr, dmem_wdata, dmem_we, dmem_re
    );

    // The host plus memory model around the engine
    modport master (
        output start, src_addr, dst_addr, len, fill, fill_word, dmem_rdata,
        input  busy, done, err, dmem_addr, dmem_wdata, dmem_we, dmem_re
    );
endinterface

// File: rtl/ternary_dma.sv
// Balanced-ternary block-copy / block-fill DMA engine.
// Copies len words from src to dst in ascending order (read then write, two
// cycles per word), or fills dst with a pattern at one word per cycle.
// Optional feature macro: TERNARY_DMA_FILL_EN enables fill mode; without it
// the fill inputs are ignored and every transfer is a copy.
// Any address that decodes negative or beyond DMEM_DEPTH-1 aborts the
// transfer with the sticky err flag set.

module ternary_dma
    import ternary_dma_pkg::*;
#(
    parameter int TRIT_WIDTH = 27,
    parameter int ADDR_WIDTH = 9,
    parameter int DMEM_DEPTH = 729
) (
    input logic          clk,
    input logic          rst,
    ternary_dma_if.slave bus
);

    typedef trit_t [ADDR_WIDTH-1:0] addr_t;
    typedef trit_t [TRIT_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    // Signed integer value of a balanced-ternary address, MSB-first Horner form
    function automatic logic signed [31:0] addr_value(input addr_t a);
        logic signed [31:0] v;
        v = '0;
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            v = v * 3;
            case (a[i])
                T_POS:   v = v + 1;
                T_NEG:   v = v - 1;
                default: v = v;
            endcase
        end
        return v;
    endfunction

    function automatic logic addr_in_range(input addr_t a);
        logic signed [31:0] v;
        v = addr_value(a);
        return (v >= 0) && (v < DMEM_DEPTH);
    endfunction

    // +1 with ripple carry from trit 0; wraps modulo 3^ADDR_WIDTH
    function automatic addr_t addr_inc(input addr_t a);
        addr_t r;
        logic  carry;
        r     = a;
        carry = 1'b1;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (carry) begin
                case (a[i])
                    T_NEG: begin
                        r[i]  = T_ZERO;
                        carry = 1'b0;
                    end
                    T_POS: begin
                        r[i]  = T_NEG;
                        carry = 1'b1;
                    end
                    default: begin
                        r[i]  = T_POS;
                        carry = 1'b0;
                    end
                endcase
            end
        end
        return r;
    endfunction

    state_t     state, state_n;
    addr_t      src_ptr, src_n;
    addr_t      dst_ptr, dst_n;
    logic [9:0] count, count_n;
    word_t      buffer, buffer_n;
    logic       err_q, err_n;

    logic       re_c, we_c;
    addr_t      addr_c;
    word_t      wdata_c;

    logic       src_ok, dst_ok;
    logic       fill_req;
    logic       fill_mode;
    word_t      fill_data;

    assign src_ok = addr_in_range(src_ptr);
    assign dst_ok = addr_in_range(dst_ptr);

`ifdef TERNARY_DMA_FILL_EN
    logic  fill_q;
    word_t fill_word_q;

    // Capture fill mode and pattern together with the rest of the command
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= 1'b0;
            fill_word_q <= '0;
        end else if (state == IDLE && bus.start) begin
            fill_q      <= bus.fill;
            fill_word_q <= bus.fill_word;
        end
    end

    assign fill_req  = bus.fill;
    assign fill_mode = fill_q;
    assign fill_data = fill_word_q;
`else
    logic unused_fill;

    assign unused_fill = ^{bus.fill, bus.fill_word};
    assign fill_req    = 1'b0;
    assign fill_mode   = 1'b0;
    assign fill_data   = '0;
`endif

    // Next-state and memory-port decode; memory port is quiet unless RD/WR
    always_comb begin
        state_n  = state;
        src_n    = src_ptr;
        dst_n    = dst_ptr;
        count_n  = count;
        buffer_n = buffer;
        err_n    = err_q;
        re_c     = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    src_n   = bus.src_addr;
                    dst_n   = bus.dst_addr;
                    count_n = bus.len;
                    err_n   = 1'b0;
                    if (bus.len == 10'd0) begin
                        state_n = DONE;
                    end else if (fill_req) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end

            RD: begin
                addr_c = src_ptr;
                if (!src_ok) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    re_c     = 1'b1;
                    buffer_n = bus.dmem_rdata;
                    state_n  = WR;
                end
            end

            WR: begin
                addr_c  = dst_ptr;
                wdata_c = fill_mode ? fill_data : buffer;
                if (!dst_ok) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    we_c    = 1'b1;
                    src_n   = addr_inc(src_ptr);
                    dst_n   = addr_inc(dst_ptr);
                    count_n = count - 10'd1;
                    if (count == 10'd1) begin
                        state_n = DONE;
                    end else if (fill_mode) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            buffer  <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            src_ptr <= src_n;
            dst_ptr <= dst_n;
            count   <= count_n;
            buffer  <= buffer_n;
            err_q   <= err_n;
        end
    end

    // Strobes are masked by rst so an access never issues in a reset cycle
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err        = err_q;
    assign bus.dmem_re    = re_c & ~rst;
    assign bus.dmem_we    = we_c & ~rst;
    assign bus.dmem_addr  = addr_c;
    assign bus.dmem_wdata = wdata_c;

endmodule

// File: tb/tb_ternary_dma.sv
// Scoreboard bench for ternary_dma: expected reads/writes are queued when a
// command is issued and popped as the DUT drives its memory port.

module tb_ternary_dma;
    import ternary_dma_pkg::*;

    localparam int TW    = 27;
    localparam int AW    = 9;
    localparam int DEPTH = 729;

    typedef trit_t [TW-1:0] word_t;
    typedef trit_t [AW-1:0] addr_t;
    typedef struct {
        addr_t addr;
        word_t data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ternary_dma_if #(.TRIT_WIDTH(TW), .ADDR_WIDTH(AW)) bus();

    ternary_dma #(
        .TRIT_WIDTH(TW),
        .ADDR_WIDTH(AW),
        .DMEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    word_t dmem  [DEPTH];
    int    model [DEPTH];
    addr_t exp_rd_q[$];
    wr_t   exp_wr_q[$];
    int    check_count = 0;
    int    error_count = 0;

    // Integer to balanced ternary by repeated balanced remainder
    function automatic word_t to_word(input int value);
        word_t w;
        int    v;
        int    r;
        v = value;
        w = '0;
        for (int i = 0; i < TW; i++) begin
            r = ((v % 3) + 3) % 3;
            if (r == 1) begin
                w[i] = T_POS;
                v    = (v - 1) / 3;
            end else if (r == 2) begin
                w[i] = T_NEG;
                v    = (v + 1) / 3;
            end else begin
                w[i] = T_ZERO;
                v    = v / 3;
            end
        end
        return w;
    endfunction

    function automatic addr_t to_addr(input int value);
        word_t w;
        w = to_word(value);
        return w[AW-1:0];
    endfunction

    // Ternary address to integer by LSB-first weighted sum
    function automatic int addr_to_int(input addr_t a);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int i = 0; i < AW; i++) begin
            if (a[i] == T_POS) v = v + p;
            if (a[i] == T_NEG) v = v - p;
            p = p * 3;
        end
        return v;
    endfunction

    function automatic int init_value(input int i);
        case (i)
            10:      return 5;
            11:      return -7;
            12:      return 13;
            default: return i * 7 - 2000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Combinational memory read
    always_comb begin
        int idx;
        idx = addr_to_int(bus.dmem_addr);
        bus.dmem_rdata = '0;
        if (idx >= 0 && idx < DEPTH) bus.dmem_rdata = dmem[idx];
    end

    // Memory owner and port monitor, sampled mid-cycle
    initial begin
        addr_t ea;
        wr_t   ew;
        int    idx;
        for (int i = 0; i < DEPTH; i++) dmem[i] = to_word(init_value(i));
        forever begin
            @(negedge clk);
            if (bus.dmem_re || bus.dmem_we)
                checkOutput("re_we_excl", 64'(bus.dmem_re & bus.dmem_we), 64'd0);
            if (!bus.busy || bus.done) begin
                checkOutput("quiet_strobes", {62'd0, bus.dmem_re, bus.dmem_we}, 64'd0);
                checkOutput("quiet_addr", 64'(bus.dmem_addr), 64'd0);
                checkOutput("quiet_wdata", 64'(bus.dmem_wdata), 64'd0);
            end
            if (bus.dmem_re) begin
                if (exp_rd_q.size() == 0) begin
                    checkOutput("rd_unexpected", 64'(bus.dmem_re), 64'd0);
                end else begin
                    ea = exp_rd_q.pop_front();
                    checkOutput("rd_addr", 64'(bus.dmem_addr), 64'(ea));
                end
            end
            if (bus.dmem_we) begin
                if (exp_wr_q.size() == 0) begin
                    checkOutput("wr_unexpected", 64'(bus.dmem_we), 64'd0);
                end else begin
                    ew = exp_wr_q.pop_front();
                    checkOutput("wr_addr", 64'(bus.dmem_addr), 64'(ew.addr));
                    checkOutput("wr_data", 64'(bus.dmem_wdata), 64'(ew.data));
                end
                idx = addr_to_int(bus.dmem_addr);
                if (idx >= 0 && idx < DEPTH) dmem[idx] = bus.dmem_wdata;
            end
        end
    end

    // Queue an in-order copy of n words and apply it to the reference image
    task automatic queueCopy(input int src, input int dst, input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(to_addr(src + k));
            w.addr = to_addr(dst + k);
            w.data = to_word(model[src + k]);
            exp_wr_q.push_back(w);
            model[dst + k] = model[src + k];
        end
    endtask

    // Issue one command; returns at the negedge of the first cycle after start
    task automatic applyStimulus(input int src, input int dst, input int n,
                                 input logic fill, input int fill_value);
        @(negedge clk);
        bus.src_addr  = to_addr(src);
        bus.dst_addr  = to_addr(dst);
        bus.len       = 10'(n);
        bus.fill      = fill;
        bus.fill_word = to_word(fill_value);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Wait (bounded) for done; check latency, busy span, err and pulse width
    task automatic waitDone(input int exp_cycles, input logic exp_err, input logic glitch);
        int   cycles;
        int   busy_cycles;
        logic seen;
        cycles      = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && cycles <= 200) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (glitch && cycles == 2) begin
                    bus.start    = 1'b1;
                    bus.src_addr = to_addr(700);
                    bus.len      = 10'd1;
                end
                if (glitch && cycles == 3) bus.start = 1'b0;
                @(negedge clk);
                cycles++;
            end
        end
        bus.start = 1'b0;
        checkOutput("done_seen", 64'(seen), 64'd1);
        checkOutput("latency", 64'(cycles), 64'(exp_cycles));
        checkOutput("busy_cycles", 64'(busy_cycles), 64'(exp_cycles));
        checkOutput("err_at_done", 64'(bus.err), 64'(exp_err));
        @(negedge clk);
        checkOutput("done_pulse", 64'(bus.done), 64'd0);
        checkOutput("busy_after", 64'(bus.busy), 64'd0);
        checkOutput("err_sticky", 64'(bus.err), 64'(exp_err));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
        checkOutput({tag, "_err"}, 64'(bus.err), 64'd0);
        checkOutput({tag, "_strobes"}, {62'd0, bus.dmem_re, bus.dmem_we}, 64'd0);
        checkOutput({tag, "_addr"}, 64'(bus.dmem_addr), 64'd0);
        checkOutput({tag, "_wdata"}, 64'(bus.dmem_wdata), 64'd0);
    endtask

    // Main sequence
    initial begin
        wr_t w;
        int  bad;

        for (int i = 0; i < DEPTH; i++) model[i] = init_value(i);
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.len       = '0;
        bus.fill      = 1'b0;
        bus.fill_word = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        // Basic copy, with a start pulse while busy that must be ignored
        $display("[TB] copy 10..12 -> 100..102");
        queueCopy(10, 100, 3);
        applyStimulus(10, 100, 3, 1'b0, 0);
        waitDone(7, 1'b0, 1'b1);
        checkOutput("copy_w0", 64'(dmem[100]), 64'(to_word(5)));
        checkOutput("copy_w1", 64'(dmem[101]), 64'(to_word(-7)));
        checkOutput("copy_w2", 64'(dmem[102]), 64'(to_word(13)));

        // Destination runs off the top of memory
        $display("[TB] range abort at 729");
        queueCopy(50, 727, 2);
        exp_rd_q.push_back(to_addr(52));
        applyStimulus(50, 727, 4, 1'b0, 0);
        waitDone(7, 1'b1, 1'b0);

        // Zero length: no accesses, err cleared by the new command
        $display("[TB] zero length");
        applyStimulus(30, 31, 0, 1'b0, 0);
        waitDone(1, 1'b0, 1'b0);

        // Carry ripple from ++ (4) to +-- (5)
        $display("[TB] carry across trits");
        queueCopy(4, 600, 2);
        applyStimulus(4, 600, 2, 1'b0, 0);
        waitDone(5, 1'b0, 1'b0);

        // Negative source aborts before any read
        $display("[TB] negative source");
        applyStimulus(-3, 10, 1, 1'b0, 0);
        waitDone(2, 1'b1, 1'b0);

        // Fill request: a fill when the feature is built, a copy otherwise
        $display("[TB] fill request");
`ifdef TERNARY_DMA_FILL_EN
        for (int k = 0; k < 5; k++) begin
            w.addr = to_addr(k);
            w.data = to_word(-1);
            exp_wr_q.push_back(w);
            model[k] = -1;
        end
        applyStimulus(400, 0, 5, 1'b1, -1);
        waitDone(6, 1'b0, 1'b0);
`else
        queueCopy(400, 0, 5);
        applyStimulus(400, 0, 5, 1'b1, -1);
        waitDone(11, 1'b0, 1'b0);
`endif

        // Reset asserted during the write of word 2 of 4
        $display("[TB] reset mid-transfer");
        exp_rd_q.push_back(to_addr(200));
        exp_rd_q.push_back(to_addr(201));
        w.addr = to_addr(300);
        w.data = to_word(model[200]);
        exp_wr_q.push_back(w);
        model[300] = model[200];
        applyStimulus(200, 300, 4, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkResetState("mid_reset");
        rst = 1'b0;
        checkOutput("reset_word2", 64'(dmem[301]), 64'(to_word(init_value(301))));

        repeat (3) @(negedge clk);
        checkOutput("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
        checkOutput("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dmem[i] !== to_word(model[i])) bad++;
        checkOutput("mem_image", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
